// File: rtl/seg7_sequence_checker.sv
// Watches a 7-segment display bus, debounces each pattern, decodes it to a digit and
// checks that successive digits count up by one (mod 10), flagging gaps and garbage.
module seg7_sequence_checker #(
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_RUN      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       seq_error,
    output logic       bad_pattern,
    output logic [7:0] err_count,
    output logic       locked
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_CHECK    = 1'b1;
    localparam logic [3:0] STAB_MAX    = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] LOCK_MAX    = 4'(LOCK_RUN);

    logic [6:0] sample_q, sample_d;
    logic       sample_vld_q, sample_vld_d;
    logic [3:0] stab_q, stab_d;
    logic [6:0] last_q, last_d;
    logic [0:0] state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] run_q, run_d;
    logic [3:0] digit_q, digit_d;
    logic       dv_q, dv_d;
    logic       se_q, se_d;
    logic       bp_q, bp_d;
    logic [7:0] err_q, err_d;
    logic       locked_q, locked_d;

    logic [3:0] dec_digit;
    logic       dec_ok;
    logic       dec_blank;
    logic       match;
    logic       accept;
    logic [3:0] next_prev;
    logic [7:0] err_inc;

    always_comb begin
        dec_digit = 4'd0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (seg_in)
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
            7'h00: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // stab_q counts repeats of sample_q; the window completes on the edge that
    // brings it to STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th identical sample.
    assign match     = sample_vld_q && (seg_in == sample_q);
    assign accept    = match && (stab_q == STAB_MAX - 4'd1) && (seg_in != last_q);
    assign next_prev = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
    assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_comb begin
        sample_d     = sample_q;
        sample_vld_d = sample_vld_q;
        stab_d       = stab_q;
        last_d       = last_q;
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        digit_d      = digit_q;
        dv_d         = 1'b0;
        se_d         = 1'b0;
        bp_d         = 1'b0;
        err_d        = err_q;
        locked_d     = locked_q;
        if (!ena) begin
            sample_vld_d = 1'b0;
            stab_d       = 4'd0;
        end else begin
            sample_d     = seg_in;
            sample_vld_d = 1'b1;
            if (!match)
                stab_d = 4'd0;
            else if (stab_q != STAB_MAX)
                stab_d = stab_q + 4'd1;
            if (accept) begin
                last_d = seg_in;
                if (dec_blank) begin
                    // blank only re-arms acceptance of the next pattern
                end else if (!dec_ok) begin
                    bp_d     = 1'b1;
                    err_d    = err_inc;
                    run_d    = 4'd0;
                    locked_d = 1'b0;
                    state_d  = ST_UNLOCKED;
                end else begin
                    dv_d    = 1'b1;
                    digit_d = dec_digit;
                    prev_d  = dec_digit;
                    if (state_q == ST_UNLOCKED) begin
                        run_d   = 4'd0;
                        state_d = ST_CHECK;
                    end else if (dec_digit == next_prev) begin
                        run_d = (run_q == LOCK_MAX) ? run_q : run_q + 4'd1;
                        if (run_d == LOCK_MAX)
                            locked_d = 1'b1;
                    end else begin
                        se_d     = 1'b1;
                        err_d    = err_inc;
                        run_d    = 4'd0;
                        locked_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q     <= 7'h00;
            sample_vld_q <= 1'b0;
            stab_q       <= 4'd0;
            last_q       <= 7'h00;
            state_q      <= ST_UNLOCKED;
            prev_q       <= 4'd0;
            run_q        <= 4'd0;
            digit_q      <= 4'd0;
            dv_q         <= 1'b0;
            se_q         <= 1'b0;
            bp_q         <= 1'b0;
            err_q        <= 8'd0;
            locked_q     <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            stab_q       <= stab_d;
            last_q       <= last_d;
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            digit_q      <= digit_d;
            dv_q         <= dv_d;
            se_q         <= se_d;
            bp_q         <= bp_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = dv_q;
    assign seq_error   = se_q;
    assign bad_pattern = bp_q;
    assign err_count   = err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Directed bench for seg7_sequence_checker: a per-edge reference model predicts each
// acceptance event into a queue, which is popped and compared when the DUT pulses.
module tb_seg7_sequence_checker;

    localparam int STABLE = 4;
    localparam int LOCKN  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       seq_error;
    logic       bad_pattern;
    logic [7:0] err_count;
    logic       locked;

    seg7_sequence_checker #(.STABLE_CYCLES(STABLE), .LOCK_RUN(LOCKN)) dut (
        .clk(clk), .rst(rst), .ena(ena), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .seq_error(seq_error),
        .bad_pattern(bad_pattern), .err_count(err_count), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [2:0] pulses;   // {digit_valid, seq_error, bad_pattern}
    } ev_t;

    ev_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [6:0] m_samp, m_last;
    bit         m_vld, m_check, m_locked;
    int         m_cnt, m_prev, m_run, m_digit, m_err;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int lookup(input logic [6:0] p);
        if (p == 7'h00) return -1;
        for (int i = 0; i < 10; i++)
            if (SEG_TAB[i] == p) return i;
        return -2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_samp = 7'h00; m_last = 7'h00; m_vld = 0; m_check = 0; m_locked = 0;
        m_cnt = 0; m_prev = 0; m_run = 0; m_digit = 0; m_err = 0;
        q.delete();
    endtask

    // Predict this edge, take it, then compare the registered outputs.
    task automatic step();
        int   old_cnt, d;
        ev_t  ev;
        if (rst) begin
            model_reset();
        end else if (!ena) begin
            m_vld = 0;
            m_cnt = 0;
        end else begin
            old_cnt = m_cnt;
            if (m_vld && seg_in == m_samp) m_cnt = (m_cnt < STABLE) ? m_cnt + 1 : STABLE;
            else m_cnt = 1;
            m_samp = seg_in;
            m_vld  = 1;
            if (old_cnt < STABLE && m_cnt == STABLE && seg_in != m_last) begin
                m_last = seg_in;
                d = lookup(seg_in);
                ev.cyc = cyc + 1;
                ev.pulses = 3'b000;
                if (d == -2) begin
                    ev.pulses = 3'b001;
                    if (m_err < 255) m_err++;
                    m_run = 0; m_locked = 0; m_check = 0;
                end else if (d >= 0) begin
                    ev.pulses = 3'b100;
                    if (!m_check) begin
                        m_run = 0; m_check = 1;
                    end else if (d == (m_prev + 1) % 10) begin
                        if (m_run < LOCKN) m_run++;
                        if (m_run == LOCKN) m_locked = 1;
                    end else begin
                        ev.pulses = 3'b110;
                        if (m_err < 255) m_err++;
                        m_run = 0; m_locked = 0;
                    end
                    m_prev = d; m_digit = d;
                end
                if (ev.pulses != 3'b000) q.push_back(ev);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ev = q.pop_front();
            chk("pulses", {29'd0, digit_valid, seq_error, bad_pattern}, {29'd0, ev.pulses});
        end else begin
            chk("no_pulse", {29'd0, digit_valid, seq_error, bad_pattern}, 32'd0);
        end
        chk("digit", {28'd0, digit}, m_digit);
        chk("err_count", {24'd0, err_count}, m_err);
        chk("locked", {31'd0, locked}, {31'd0, m_locked});
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; seg_in = 7'h00;
        model_reset();
        step(); step();
        rst = 1'b0;
        chk("reset_outputs", {24'd0, digit, digit_valid, seq_error, bad_pattern, locked},
            32'd0);
        chk("reset_err", {24'd0, err_count}, 32'd0);

        // glitch: 0x06 for 3 cycles is never accepted; 0x3F pulses right after its 4th edge
        hold(7'h06, 3);
        hold(7'h3F, 3);
        chk("glitch_no_early", {31'd0, digit_valid}, 32'd0);
        step();
        chk("glitch_latency", {31'd0, digit_valid}, 32'd1);
        hold(7'h3F, 6);

        // clean count 0..3
        hold(7'h06, 10); hold(7'h5B, 10); hold(7'h4F, 10);
        chk("clean_locked", {31'd0, locked}, 32'd1);
        chk("clean_err", {24'd0, err_count}, 32'd0);
        chk("clean_digit", {28'd0, digit}, 32'd3);

        // continue to 9, wrap to 0, then skip to 3
        hold(7'h66, 5); hold(7'h6D, 5); hold(7'h7D, 5);
        hold(7'h07, 5); hold(7'h7F, 5); hold(7'h6F, 5);
        hold(7'h3F, 5);
        chk("wrap_locked", {31'd0, locked}, 32'd1);
        chk("wrap_digit", {28'd0, digit}, 32'd0);
        hold(7'h4F, 5);
        chk("skip_locked", {31'd0, locked}, 32'd0);
        chk("skip_err", {24'd0, err_count}, 32'd1);
        chk("skip_digit", {28'd0, digit}, 32'd3);

        // blank, bad, recover without check, repeat after blank
        hold(7'h00, 6);
        hold(7'h7E, 6);
        chk("bad_err", {24'd0, err_count}, 32'd2);
        chk("bad_digit", {28'd0, digit}, 32'd3);
        hold(7'h66, 6);
        hold(7'h00, 6);
        hold(7'h66, 6);
        chk("repeat_err", {24'd0, err_count}, 32'd3);

        // enable low clears the window
        hold(7'h6D, 2);
        ena = 1'b0;
        hold(7'h6D, 3);
        ena = 1'b1;
        hold(7'h6D, 3);
        chk("ena_no_early", {31'd0, digit_valid}, 32'd0);
        step();
        chk("ena_accept", {31'd0, digit_valid}, 32'd1);
        chk("ena_digit", {28'd0, digit}, 32'd5);

        // saturation
        for (int k = 0; k < 300; k++) begin
            hold(7'h3F, STABLE);
            hold(7'h7E, STABLE);
        end
        chk("sat_err", {24'd0, err_count}, 32'd255);

        // reset mid-window, then a full window is needed again
        hold(7'h06, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outputs", {24'd0, digit, digit_valid, seq_error, bad_pattern, locked},
            32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        hold(7'h06, 3);
        chk("rst_requalify", {31'd0, digit_valid}, 32'd0);
        step();
        chk("rst_accept", {31'd0, digit_valid}, 32'd1);
        chk("rst_digit", {28'd0, digit}, 32'd1);
        hold(7'h06, 3);

        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_sequence_checker.md
SEG7_SEQUENCE_CHECKER -- requirements
Module: seg7_sequence_checker

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, 4, consecutive identical samples needed to accept a pattern (legal 2..15).
REQ-002 SHALL have parameter: LOCK_RUN, 3, consecutive correct increments needed to assert locked (legal 1..15).
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: ena  input  1  enable; low freezes the checker.
REQ-006 SHALL have port: seg_in  input  7  segment pattern, bit0=a ... bit6=g, active-high (common-cathode).
REQ-007 SHALL have port: digit  output  4  last accepted decimal digit.
REQ-008 SHALL have port: digit_valid  output  1  one-cycle pulse when a new digit is accepted.
REQ-009 SHALL have port: seq_error  output  1  one-cycle pulse when an accepted digit is not prev+1 mod 10.
REQ-010 SHALL have port: bad_pattern  output  1  one-cycle pulse when an unrecognised non-blank pattern is accepted.
REQ-011 SHALL have port: err_count  output  8  saturating count of seq_error plus bad_pattern events.
REQ-012 SHALL have port: locked  output  1  high while the display is counting correctly.

Function
REQ-013 SHALL decode, and only decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; 0x00=blank; every other value is bad.
REQ-014 SHALL register seg_in once per cycle; a stability counter increments while the sample equals the previous sample and clears to 0 on any change.
REQ-015 SHALL accept a pattern when it has been sampled identically on STABLE_CYCLES consecutive edges and it differs from the last accepted pattern; each stable pattern is accepted exactly once.
REQ-016 SHALL present all outputs registered: the pulse and the updated digit appear in the cycle after the edge on which acceptance occurs; digit holds between acceptances.
REQ-017 SHALL, on acceptance of a blank, update the last-accepted pattern only: no pulse, digit, state and prev-digit unchanged.
REQ-018 SHALL implement states UNLOCKED and CHECK; the reset state is UNLOCKED.
REQ-019 SHALL, in UNLOCKED, on acceptance of a valid digit d: set digit=d, pulse digit_valid, store prev=d, clear good_run, go to CHECK, and perform no sequence check.
REQ-020 SHALL, in CHECK, on acceptance of a valid digit d == (prev+1) mod 10 (9 wraps to 0): pulse digit_valid, and increment good_run saturating at LOCK_RUN; locked=1 when good_run reaches LOCK_RUN.
REQ-021 SHALL, in CHECK, on acceptance of a valid digit with any other value, including a repeat after a blank: pulse digit_valid and seq_error, increment err_count, clear good_run and locked, set prev=d, and stay in CHECK.
REQ-022 SHALL, in any state, on acceptance of a bad pattern: pulse bad_pattern, increment err_count, clear good_run and locked, go to UNLOCKED; digit unchanged.
REQ-023 SHALL saturate err_count at 255; at most one increment per cycle.
REQ-024 SHALL, while ena=0, hold all state, counters and outputs, force pulses low and clear the stability counter; after ena rises, a full STABLE_CYCLES window is required before acceptance.

Reset
REQ-025 SHALL, with rst=1 at an edge, set digit=0, digit_valid=0, seq_error=0, bad_pattern=0, err_count=0, locked=0, state=UNLOCKED, good_run=0, stability counter=0, and last-accepted pattern=0x00, regardless of ena or operation in progress.
REQ-026 SHALL take rst priority over ena and all other activity; a pattern mid-window at reset must be re-qualified for a full window.

Verification
REQ-027 SHALL cover clean count: seg_in 0x3F,0x06,0x5B,0x4F each held 10 cycles, defaults -> digit_valid x4, seq_error never, locked=1 after 0x4F accepted, err_count=0.
REQ-028 SHALL cover glitch filter: 0x06 held 3 cycles then 0x3F (STABLE_CYCLES=4) -> no acceptance of 0x06; digit_valid latency after the 4th stable edge exactly one cycle.
REQ-029 SHALL cover wrap and skip: locked at 0x6F(9), then 0x3F(0) -> ok and locked stays 1; then 0x4F(3) -> seq_error pulse, locked=0, err_count+1, digit=3.
REQ-030 SHALL cover bad and blank: 0x00 held -> no pulses; 0x7E held -> bad_pattern pulse, state UNLOCKED; next 0x66 -> digit_valid, no seq_error.
REQ-031 SHALL cover saturation and reset: 300 alternating 0x3F/0x7E events -> err_count=255; rst for one cycle mid-window -> all outputs 0 on the next cycle.
